// File: rtl/control_filtro_pa20_pkg.sv
// rtl/control_filtro_pa20_pkg.sv - shared state encoding and mux select codes for the biquad controller
package control_filtro_pa20_pkg;

   // Controller sequence: one multiply-accumulate per C-state, then history shift.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      C1    = 3'd1,
      C2    = 3'd2,
      C3    = 3'd3,
      C4    = 3'd4,
      C5    = 3'd5,
      SHIFT = 3'd6,
      DONE  = 3'd7
   } state_t;

   // Addend (S) operand of result = S + C*Z.
   typedef enum logic [2:0] {
      S_FK    = 3'd0,
      S_FK1   = 3'd1,
      S_FK2   = 3'd2,
      S_ZERO  = 3'd3,
      S_UK    = 3'd4,
      S_ACUM1 = 3'd5,
      S_ACUM2 = 3'd6,
      S_ACUM3 = 3'd7
   } sel_s_t;

   // Signal (Z) operand of result = S + C*Z.
   typedef enum logic [2:0] {
      Z_FK  = 3'd0,
      Z_FK1 = 3'd1,
      Z_FK2 = 3'd2
   } sel_z_t;

   // Coefficient (C) operand; a1/a2 are stored negated, b2 reuses b0.
   typedef enum logic [1:0] {
      C_A1N = 2'd0,
      C_A2N = 2'd1,
      C_B0  = 2'd2,
      C_B1  = 2'd3
   } sel_c_t;

   // States in which a new start cannot be accepted.
   function automatic logic is_computing(input state_t s);
      return (s inside {C1, C2, C3, C4, C5, SHIFT});
   endfunction

endpackage

// File: rtl/control_filtro_pa20_divisor_muestreo.sv
// rtl/control_filtro_pa20_divisor_muestreo.sv - free-running sample period divider
module divisor_muestreo #(
   parameter int SAMPLE_DIV = 5000
) (
   input  logic clk,
   input  logic reset,
   output logic sample_tick
);

   localparam int W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(SAMPLE_DIV - 1);

   logic [W-1:0] count;

   // Count 0..SAMPLE_DIV-1 and wrap, independent of the filter sequence.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign sample_tick = (count == LAST);

endmodule

// File: rtl/control_filtro_pa20.sv
// rtl/control_filtro_pa20.sv - sequencing FSM for a high-pass DF-II biquad datapath (result = S + C*Z)
module control_filtro_pa20
   import control_filtro_pa20_pkg::*;
#(
   parameter int SAMPLE_DIV = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       clr_overrun,
   output logic       en1,
   output logic       en2,
   output logic       en3,
   output logic       en4,
   output logic       en5,
   output logic       en6,
   output logic       en7,
   output logic [2:0] selmuxS,
   output logic [2:0] selmuxZ,
   output logic [1:0] selmuxC,
   output logic       busy,
   output logic       done,
   output logic       overrun,
   output logic       sample_tick
);

   state_t state;
   state_t state_nxt;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and Moore output decode from the state register.
   always_comb begin
      state_nxt = state;
      en1       = 1'b0;
      en2       = 1'b0;
      en3       = 1'b0;
      en4       = 1'b0;
      en5       = 1'b0;
      en6       = 1'b0;
      en7       = 1'b0;
      selmuxS   = S_FK;
      selmuxZ   = Z_FK;
      selmuxC   = C_A1N;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = C1;
         end
         C1: begin
            // acum1 = uk - a1*fk1
            selmuxS   = S_UK;
            selmuxC   = C_A1N;
            selmuxZ   = Z_FK1;
            en5       = 1'b1;
            state_nxt = C2;
         end
         C2: begin
            // fk = acum1 - a2*fk2
            selmuxS   = S_ACUM1;
            selmuxC   = C_A2N;
            selmuxZ   = Z_FK2;
            en2       = 1'b1;
            state_nxt = C3;
         end
         C3: begin
            // acum2 = b0*fk
            selmuxS   = S_ZERO;
            selmuxC   = C_B0;
            selmuxZ   = Z_FK;
            en6       = 1'b1;
            state_nxt = C4;
         end
         C4: begin
            // acum3 = acum2 + b1*fk1
            selmuxS   = S_ACUM2;
            selmuxC   = C_B1;
            selmuxZ   = Z_FK1;
            en7       = 1'b1;
            state_nxt = C5;
         end
         C5: begin
            // yk = acum3 + b0*fk2 (b2 == b0)
            selmuxS   = S_ACUM3;
            selmuxC   = C_B0;
            selmuxZ   = Z_FK2;
            en1       = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            // fk2 <= fk1 and fk1 <= fk on the same edge
            en3       = 1'b1;
            en4       = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? C1 : IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Sticky overrun: a start arriving mid-computation is dropped and flagged; set beats clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else if (start && is_computing(state)) begin
         overrun <= 1'b1;
      end else if (clr_overrun) begin
         overrun <= 1'b0;
      end
   end

   divisor_muestreo #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_divisor_muestreo (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick)
   );

endmodule

// File: tb/tb_control_filtro_pa20.sv
// tb/tb_control_filtro_pa20.sv - scoreboard bench for the biquad controller
module tb_control_filtro_pa20;

   localparam int DIV = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic clr_overrun = 1'b0;
   logic en1, en2, en3, en4, en5, en6, en7;
   logic [2:0] selmuxS;
   logic [2:0] selmuxZ;
   logic [1:0] selmuxC;
   logic busy, done, overrun, sample_tick;

   always #5 clk = ~clk;

   control_filtro_pa20 #(
      .SAMPLE_DIV (DIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .clr_overrun (clr_overrun),
      .en1         (en1),
      .en2         (en2),
      .en3         (en3),
      .en4         (en4),
      .en5         (en5),
      .en6         (en6),
      .en7         (en7),
      .selmuxS     (selmuxS),
      .selmuxZ     (selmuxZ),
      .selmuxC     (selmuxC),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .sample_tick (sample_tick)
   );

   // {en7..en1, S, C, Z, busy, done}
   logic [16:0] dut_vec;
   assign dut_vec = {en7, en6, en5, en4, en3, en2, en1, selmuxS, selmuxC, selmuxZ, busy, done};

   typedef struct {
      int          cyc;
      logic [16:0] vec;
      logic [16:0] mask;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   seq_end = -1;
   logic ov_exp = 1'b0;
   logic ov_next = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [16:0] pk(input logic [6:0] en, input logic [2:0] s,
                                      input logic [1:0] c, input logic [2:0] z, input logic d);
      return {en, s, c, z, 1'b1, d};
   endfunction

   // Expected outputs for the k-th cycle after an accepted start (C1..C5, SHIFT, DONE).
   function automatic logic [16:0] step_vec(input int k);
      case (k)
         0:       return pk(7'b0010000, 3'd4, 2'd0, 3'd1, 1'b0);
         1:       return pk(7'b0000010, 3'd5, 2'd1, 3'd2, 1'b0);
         2:       return pk(7'b0100000, 3'd3, 2'd2, 3'd0, 1'b0);
         3:       return pk(7'b1000000, 3'd6, 2'd3, 3'd1, 1'b0);
         4:       return pk(7'b0000001, 3'd7, 2'd2, 3'd2, 1'b0);
         5:       return pk(7'b0001100, 3'd0, 2'd0, 3'd0, 1'b0);
         default: return pk(7'b0000000, 3'd0, 2'd0, 3'd0, 1'b1);
      endcase
   endfunction

   // Reference: a start is accepted unless a sequence is still before its DONE cycle.
   task automatic model(input logic s, input logic c);
      exp_t x;
      if (s && cyc < seq_end) begin
         ov_next = 1'b1;
      end else begin
         if (c) ov_next = 1'b0;
         if (s) begin
            for (int k = 0; k < 7; k++) begin
               x.cyc  = cyc + 1 + k;
               x.vec  = step_vec(k);
               x.mask = (k == 5) ? 17'b1111111_000_00_000_11 : '1;
               q.push_back(x);
            end
            seq_end = cyc + 7;
         end
      end
   endtask

   task automatic step(input logic s, input logic c);
      start = s;
      clr_overrun = c;
      model(s, c);
      @(posedge clk);
      #1;
      cyc++;
      ov_exp = ov_next;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      clr_overrun = 1'b0;
      #1;
      chk("async_reset", {15'd0, dut_vec, overrun, sample_tick}, 32'd0);
      q.delete();
      seq_end = -1;
      ov_next = 1'b0;
      ov_exp  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc = 0;
   endtask

   // Monitor: busy acts as the valid; each busy cycle consumes one scoreboard entry.
   always @(negedge clk) begin
      if (!reset) begin
         chk("reset_outputs", {15'd0, dut_vec, overrun, sample_tick}, 32'd0);
      end else begin
         chk("sample_tick", {31'd0, sample_tick}, {31'd0, (cyc % DIV) == DIV - 1});
         chk("overrun", {31'd0, overrun}, {31'd0, ov_exp});
         if (busy) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_busy: got busy=1 expected busy=0 at cycle %0d", cyc);
            end else begin
               e = q.pop_front();
               chk("step_cycle", cyc, e.cyc);
               chk("step_outputs", {15'd0, dut_vec & e.mask}, {15'd0, e.vec & e.mask});
            end
         end else begin
            chk("idle_outputs", {15'd0, dut_vec}, 32'd0);
            if (q.size() > 0 && q[0].cyc <= cyc) begin
               checks++;
               errors++;
               $display("FAIL missing_step: got busy=0 expected busy=1 at cycle %0d", cyc);
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      cyc = 0;
      // idle after reset
      repeat (10) step(1'b0, 1'b0);
      do_reset();
      // single start at cycle 3, done expected at cycle 10
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (9) step(1'b0, 1'b0);
      // start again during C3, then clear overrun
      step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      // start pulsed in DONE: back-to-back sequences, no overrun
      step(1'b1, 1'b0);
      repeat (6) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (9) step(1'b0, 1'b0);
      // same-cycle start and clear while busy: set wins
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      repeat (7) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      // reset during C4, then a full sequence
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      do_reset();
      step(1'b1, 1'b0);
      repeat (9) step(1'b0, 1'b0);
      // randomized traffic
      repeat (600) step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      repeat (10) step(1'b0, 1'b0);
      chk("queue_empty", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
